// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grants one valid/ready request per cycle onto the
// shared memory port, bounds monopolisation with a hold counter, registers read data.
module dmem_arbiter #(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req0_valid,
   input  logic                          req0_write,
   input  logic [2:0]                    req0_op,
   input  logic [ADDR_W-1:0]             req0_addr,
   input  logic [DATA_W-1:0]             req0_wdata,
   output logic                          req0_ready,
   input  logic                          req1_valid,
   input  logic                          req1_write,
   input  logic [2:0]                    req1_op,
   input  logic [ADDR_W-1:0]             req1_addr,
   input  logic [DATA_W-1:0]             req1_wdata,
   output logic                          req1_ready,
   output logic                          rsp0_valid,
   output logic [DATA_W-1:0]             rsp0_rdata,
   output logic                          rsp1_valid,
   output logic [DATA_W-1:0]             rsp1_rdata,
   output logic                          memwrite,
   output logic                          memread,
   output logic [2:0]                    memop,
   output logic [ADDR_W-1:0]             memaddr,
   output logic [DATA_W-1:0]             memdatain,
   input  logic [DATA_W-1:0]             memdataout,
   output logic [1:0]                    dbg_state,
   output logic [$clog2(MAX_HOLD+1)-1:0] dbg_hold_cnt,
   output logic                          dbg_rr
);

   localparam int HW = $clog2(MAX_HOLD+1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic          rr, rr_nxt;
   logic          gnt0, gnt1;

   // Handshake: a request transfers on a rising edge where valid && ready; ready is
   // combinational from valid and arbiter state, valid never depends on ready, and
   // request fields are held stable while valid is high and ready is low.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state)
         IDLE: begin
            if (req0_valid && req1_valid) begin
               gnt0 = ~rr;
               gnt1 = rr;
            end else begin
               gnt0 = req0_valid;
               gnt1 = req1_valid;
            end
         end
         OWN0: begin
            if (req0_valid && (hold_cnt < HOLD_MAX || !req1_valid)) gnt0 = 1'b1;
            else                                                    gnt1 = req1_valid;
         end
         OWN1: begin
            if (req1_valid && (hold_cnt < HOLD_MAX || !req0_valid)) gnt1 = 1'b1;
            else                                                    gnt0 = req0_valid;
         end
         default: ;
      endcase
      // Held reset masks grants so nothing reaches memory, even mid-cycle.
      if (!rst) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      hold_nxt  = '0;
      rr_nxt    = rr;
      if (gnt0) begin
         if (state == OWN0) begin
            state_nxt = OWN0;
            hold_nxt  = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
         end else begin
            state_nxt = OWN0;
            hold_nxt  = HW'(1);
            rr_nxt    = 1'b1;
         end
      end else if (gnt1) begin
         if (state == OWN1) begin
            state_nxt = OWN1;
            hold_nxt  = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
         end else begin
            state_nxt = OWN1;
            hold_nxt  = HW'(1);
            rr_nxt    = 1'b0;
         end
      end
   end

   always_comb begin
      memwrite  = 1'b0;
      memread   = 1'b0;
      memop     = '0;
      memaddr   = '0;
      memdatain = '0;
      if (gnt0) begin
         memwrite  = req0_write;
         memread   = ~req0_write;
         memop     = req0_op;
         memaddr   = req0_addr;
         memdatain = req0_wdata;
      end else if (gnt1) begin
         memwrite  = req1_write;
         memread   = ~req1_write;
         memop     = req1_op;
         memaddr   = req1_addr;
         memdatain = req1_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         rr       <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         rr       <= rr_nxt;
      end
   end

   // Read data is captured at the accepting edge; rdata holds between reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp0_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_valid <= 1'b0;
         rsp1_rdata <= '0;
      end else begin
         rsp0_valid <= gnt0 & ~req0_write;
         rsp1_valid <= gnt1 & ~req1_write;
         if (gnt0 && !req0_write) rsp0_rdata <= memdataout;
         if (gnt1 && !req1_write) rsp1_rdata <= memdataout;
      end
   end

   assign req0_ready   = gnt0;
   assign req1_ready   = gnt1;
   assign dbg_state    = state;
   assign dbg_hold_cnt = hold_cnt;
   assign dbg_rr       = rr;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MAX_HOLD 4 and 1) share stimulus; a per-cycle
// behavioural model plus literal expectations check grants, memory port and responses.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        vld [2];
   logic        wr  [2];
   logic [2:0]  op  [2];
   logic [8:0]  addr[2];
   logic [31:0] wd  [2];

   logic        rdy0[2], rdy1[2], rv0[2], rv1[2], mw[2], mr[2], drr[2];
   logic [31:0] rd0[2], rd1[2], mdin[2], mdout[2];
   logic [2:0]  mop[2];
   logic [8:0]  maddr[2];
   logic [1:0]  dst[2];
   logic [2:0]  dhc0;
   logic [0:0]  dhc1;

   logic [31:0] mem [2][512] = '{default: '0};

   assign mdout[0] = mem[0][maddr[0]];
   assign mdout[1] = mem[1][maddr[1]];

   always @(posedge clk)
      for (int k = 0; k < 2; k++)
         if (mw[k]) mem[k][maddr[k]] <= mdin[k];

   dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_HOLD(4)) u_dut0 (
      .clk(clk), .rst(rst),
      .req0_valid(vld[0]), .req0_write(wr[0]), .req0_op(op[0]), .req0_addr(addr[0]),
      .req0_wdata(wd[0]), .req0_ready(rdy0[0]),
      .req1_valid(vld[1]), .req1_write(wr[1]), .req1_op(op[1]), .req1_addr(addr[1]),
      .req1_wdata(wd[1]), .req1_ready(rdy1[0]),
      .rsp0_valid(rv0[0]), .rsp0_rdata(rd0[0]), .rsp1_valid(rv1[0]), .rsp1_rdata(rd1[0]),
      .memwrite(mw[0]), .memread(mr[0]), .memop(mop[0]), .memaddr(maddr[0]),
      .memdatain(mdin[0]), .memdataout(mdout[0]),
      .dbg_state(dst[0]), .dbg_hold_cnt(dhc0), .dbg_rr(drr[0])
   );

   dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_HOLD(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(vld[0]), .req0_write(wr[0]), .req0_op(op[0]), .req0_addr(addr[0]),
      .req0_wdata(wd[0]), .req0_ready(rdy0[1]),
      .req1_valid(vld[1]), .req1_write(wr[1]), .req1_op(op[1]), .req1_addr(addr[1]),
      .req1_wdata(wd[1]), .req1_ready(rdy1[1]),
      .rsp0_valid(rv0[1]), .rsp0_rdata(rd0[1]), .rsp1_valid(rv1[1]), .rsp1_rdata(rd1[1]),
      .memwrite(mw[1]), .memread(mr[1]), .memop(mop[1]), .memaddr(maddr[1]),
      .memdatain(mdin[1]), .memdataout(mdout[1]),
      .dbg_state(dst[1]), .dbg_hold_cnt(dhc1), .dbg_rr(drr[1])
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (inst%0d, MAX_HOLD=%0d) t=%0t: got %h, expected %h",
                  nm, k, mh(k), $time, act, exp);
      end
   endtask

   // Behavioural model: owner (-1 = nobody), length of the current grant streak,
   // and the port favoured when a contended request arrives with no owner.
   int          owner [2];
   int          streak[2];
   int          fav   [2];
   logic        exp_rv[2][2];
   logic [31:0] exp_rd[2][2];
   logic [31:0] mmem  [2][512] = '{default: '0};

   function automatic int mh(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic int winner(input int k);
      if (!rst) return -1;
      if (vld[0] && vld[1]) begin
         if (owner[k] < 0)       return fav[k];
         if (streak[k] < mh(k))  return owner[k];
         return 1 - owner[k];
      end
      if (vld[0]) return 0;
      if (vld[1]) return 1;
      return -1;
   endfunction

   function automatic logic [31:0] hold_act(input int k);
      return (k == 0) ? 32'(dhc0) : 32'(dhc1);
   endfunction

   int mw_w;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            owner[k]     <= -1;
            streak[k]    <= 0;
            fav[k]       <= 0;
            exp_rv[k][0] <= 1'b0;
            exp_rv[k][1] <= 1'b0;
            exp_rd[k][0] <= '0;
            exp_rd[k][1] <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            mw_w = winner(k);
            exp_rv[k][0] <= 1'b0;
            exp_rv[k][1] <= 1'b0;
            if (mw_w >= 0) begin
               if (wr[mw_w]) mmem[k][addr[mw_w]] <= wd[mw_w];
               else begin
                  exp_rv[k][mw_w] <= 1'b1;
                  exp_rd[k][mw_w] <= mmem[k][addr[mw_w]];
               end
               if (mw_w == owner[k]) streak[k] <= streak[k] + 1;
               else begin
                  owner[k]  <= mw_w;
                  streak[k] <= 1;
                  fav[k]    <= 1 - mw_w;
               end
            end else begin
               owner[k]  <= -1;
               streak[k] <= 0;
            end
         end
      end
   end

   int cw;
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         cw = winner(k);
         chk("req0_ready", k, 32'(rdy0[k]), 32'(cw == 0));
         chk("req1_ready", k, 32'(rdy1[k]), 32'(cw == 1));
         chk("memwrite",  k, 32'(mw[k]),    (cw >= 0) ? 32'(wr[cw])  : 32'd0);
         chk("memread",   k, 32'(mr[k]),    (cw >= 0) ? 32'(!wr[cw]) : 32'd0);
         chk("memop",     k, 32'(mop[k]),   (cw >= 0) ? 32'(op[cw])  : 32'd0);
         chk("memaddr",   k, 32'(maddr[k]), (cw >= 0) ? 32'(addr[cw]) : 32'd0);
         chk("memdatain", k, mdin[k],       (cw >= 0) ? wd[cw]       : 32'd0);
         chk("rsp0_valid", k, 32'(rv0[k]), 32'(exp_rv[k][0]));
         chk("rsp1_valid", k, 32'(rv1[k]), 32'(exp_rv[k][1]));
         chk("rsp0_rdata", k, rd0[k], exp_rd[k][0]);
         chk("rsp1_rdata", k, rd1[k], exp_rd[k][1]);
         chk("state",     k, 32'(dst[k]), 32'(owner[k] + 1));
         chk("hold_cnt",  k, hold_act(k), 32'((streak[k] < mh(k)) ? streak[k] : mh(k)));
         chk("rr",        k, 32'(drr[k]), 32'(fav[k]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int p);
      vld[p]  = 1'b0;
      wr[p]   = 1'b0;
      op[p]   = '0;
      addr[p] = '0;
      wd[p]   = '0;
   endtask

   task automatic drive(input int p, input logic w, input logic [8:0] a, input logic [31:0] d);
      vld[p]  = 1'b1;
      wr[p]   = w;
      op[p]   = (p == 0) ? 3'd2 : 3'd5;
      addr[p] = a;
      wd[p]   = d;
   endtask

   logic [11:0] pat0, pat1;
   int          cnt;

   initial begin
      idle(0);
      idle(1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Port 0 write then read-back; grant available in the first cycle out of reset.
      drive(0, 1'b1, 9'h010, 32'hDEADBEEF);
      @(negedge clk) chk("lit_wr_ready0", 0, 32'(rdy0[0]), 32'd1);
      step();
      drive(0, 1'b0, 9'h010, 32'h0);
      @(negedge clk) chk("lit_rd_ready0", 0, 32'(rdy0[0]), 32'd1);
      step();
      idle(0);
      @(negedge clk);
      chk("lit_rsp0_valid", 0, 32'(rv0[0]), 32'd1);
      chk("lit_rsp0_rdata", 0, rd0[0], 32'hDEADBEEF);
      chk("lit_rsp1_quiet", 0, 32'(rv1[0]), 32'd0);
      step();

      // Port 1 write leaves rr pointing at port 0, then one idle cycle.
      drive(1, 1'b1, 9'h011, 32'h12345678);
      @(negedge clk) chk("lit_wr_ready1", 0, 32'(rdy1[0]), 32'd1);
      step();
      idle(1);
      step();

      // Continuous contention: 4/4/4 on MAX_HOLD=4, strict alternation on MAX_HOLD=1.
      drive(0, 1'b0, 9'h010, 32'h0);
      drive(1, 1'b0, 9'h011, 32'h0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         pat0[11-i] = rdy1[0];
         pat1[11-i] = rdy1[1];
         if (i == 2) begin
            chk("lit_alt_rsp1_valid", 1, 32'(rv1[1]), 32'd1);
            chk("lit_alt_rsp1_rdata", 1, rd1[1], 32'h12345678);
            chk("lit_alt_rsp0_quiet", 1, 32'(rv0[1]), 32'd0);
         end
         step();
      end
      chk("lit_pattern_hold4", 0, 32'(pat0), 32'(12'b000011110000));
      chk("lit_pattern_hold1", 1, 32'(pat1), 32'(12'b010101010101));
      idle(0);
      idle(1);
      step();

      // Port 0 alone: granted every cycle, hold counter saturates.
      drive(0, 1'b0, 9'h010, 32'h0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rdy0[0]) cnt++;
         step();
      end
      chk("lit_solo_grants", 0, 32'(cnt), 32'd10);
      @(negedge clk) chk("lit_hold_sat", 0, hold_act(0), 32'd4);
      step();
      idle(0);
      step();

      // Port 1 alone for 2 cycles, one idle cycle, then contention from IDLE.
      drive(1, 1'b0, 9'h011, 32'h0);
      step();
      step();
      idle(1);
      step();
      drive(0, 1'b0, 9'h010, 32'h0);
      drive(1, 1'b0, 9'h011, 32'h0);
      @(negedge clk);
      chk("lit_idle_state", 0, 32'(dst[0]), 32'd0);
      chk("lit_rr_zero",    0, 32'(drr[0]), 32'd0);
      chk("lit_contend_p0", 0, 32'(rdy0[0]), 32'd1);
      chk("lit_contend_p1", 0, 32'(rdy1[0]), 32'd0);
      step();

      // Reset asserted mid-cycle with a port 1 write pending.
      idle(0);
      drive(1, 1'b1, 9'h055, 32'hBAD0BAD0);
      #1;
      chk("lit_pre_memwrite", 0, 32'(mw[0]), 32'd1);
      chk("lit_pre_rsp0",     0, 32'(rv0[0]), 32'd1);
      #1 rst = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("lit_rst_memwrite", k, 32'(mw[k]),   32'd0);
         chk("lit_rst_ready1",   k, 32'(rdy1[k]), 32'd0);
         chk("lit_rst_rsp0",     k, 32'(rv0[k]),  32'd0);
         chk("lit_rst_rsp1",     k, 32'(rv1[k]),  32'd0);
      end
      step();
      chk("lit_rst_mem_kept", 0, mem[0][9'h055], 32'd0);
      chk("lit_rst_mem_kept", 1, mem[1][9'h055], 32'd0);
      idle(1);
      step();
      rst = 1'b1;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
